mem_loader: RTL
===============

Name: mem_loader

Overview:
- Upstream programming stage for the 16x8 SAP RAM.
- Accepts a byte stream over a valid/ready handshake and writes it to RAM addresses 0..15 in order, generating active-low write strobes with setup/hold margins.
- Then reads all 16 locations back through the RAM's active-low output enable and checks a mod-256 checksum.
- Replaces manual DIP-switch programming; drives the RAM's address, data, write_enable and enable pins directly.

Parameters:
- ADDR_WIDTH, 4: RAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8: RAM word width.
- WE_PULSE, 1: cycles mem_write_enable is held low per byte; must be >= 1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  begin a load at address 0; sampled only in IDLE.
- abort  input  1  synchronous cancel of a load in progress.
- in_valid  input  1  in_data holds a byte.
- in_data  input  DATA_WIDTH  byte to write.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_address  output  ADDR_WIDTH  RAM address.
- mem_data  output  DATA_WIDTH  RAM write data.
- mem_write_enable  output  1  RAM write strobe, active-low.
- mem_enable  output  1  RAM output enable, active-low.
- mem_bus  input  DATA_WIDTH  RAM read data (tri-state bus).
- busy  output  1  load or verify in progress.
- done  output  1  last load finished; held until next accepted start.
- error  output  1  checksum mismatch on last load; valid when done=1.

Behaviour:
- Reset (asynchronous, immediate, no clock required):
  - mem_address=0, mem_data=0, mem_write_enable=1, mem_enable=1.
  - in_ready=0, busy=0, done=0, error=0.
  - Both sums cleared; state IDLE.
- States: IDLE, WAIT_DATA, SETUP, WRITE, HOLD, RD_ADDR, RD_SAMPLE, CHECK.
- IDLE:
  - start=1 -> WAIT_DATA. Clear addr, wr_sum, rd_sum, done, error. Set busy=1.
  - start is ignored in every other state.
- WAIT_DATA:
  - in_ready=1 (in_ready is 1 only in this state).
  - On in_valid & in_ready: latch in_data into mem_data, add it to wr_sum (mod 256), go to SETUP.
  - No in_valid: stay, with no RAM activity.
- SETUP: one cycle; address and data stable, mem_write_enable=1.
- WRITE:
  - mem_write_enable=0 for exactly WE_PULSE cycles.
  - mem_address and mem_data stay unchanged throughout.
- HOLD:
  - One cycle, mem_write_enable=1, address and data still held.
  - If addr==DEPTH-1 -> RD_ADDR with addr=0; else addr+1 -> WAIT_DATA.
  - Address never wraps during load.
- Write throughput: with in_valid held high, each byte costs 3+WE_PULSE cycles (accept, setup, WRITE, hold).
- RD_ADDR: mem_enable=0, mem_address=addr; one settling cycle.
- RD_SAMPLE:
  - rd_sum += mem_bus (mod 256); mem_enable stays 0.
  - If addr==DEPTH-1 -> CHECK; else addr+1 -> RD_ADDR.
- CHECK:
  - error = (wr_sum != rd_sum); done=1; busy=0; mem_enable=1; go to IDLE.
  - A high-Z or X readback is treated as a mismatch.
- Verify costs 2*DEPTH+1 cycles.
- abort=1 in any non-IDLE state, at the next edge:
  - mem_write_enable=1, mem_enable=1, go to IDLE.
  - busy=0, done=0, error=1.
  - abort outranks every other transition in that cycle.
- mem_write_enable and mem_enable are never both 0 in the same cycle.
- All outputs are registered, except in_ready, which is decoded from state.

Decomposition:
- Shared include sap_defs.vh holds:
  - SAP_ADDR_WIDTH=4 and SAP_DATA_WIDTH=8 constants, reused by the RAM.
  - The loader state encodings as localparams (3-bit).
- One natural sub-module: mem_loader_checksum. It holds a DATA_WIDTH accumulator with clear/add inputs and is instantiated twice (write sum, read sum).

Test Plan:
- Reset: assert rst_n=0 mid-clock -> outputs immediately mem_write_enable=1, mem_enable=1, busy=0, done=0, error=0, mem_address=0.
- Back-to-back load of 0x00..0x0F, in_valid held high, behavioural 16x8 RAM model:
  - exactly 16 write pulses, each 1 cycle wide, at addresses 0..15;
  - RAM[k]=k; wr_sum=0x78; done=1, error=0;
  - busy high for 16*4+33=97 cycles.
- Backpressure: 0xAA,0x55,... with 3-cycle in_valid gaps -> in_ready stays 1 during the gaps, no write pulses during the gaps, final RAM contents are correct.
- Corrupted readback: RAM model returns 0xFF at address 5 (written 0x05) -> done=1, error=1.
- Mid-operation events:
  - rst_n low during WRITE of address 7 -> mem_write_enable=1 immediately; a new start reloads from address 0.
  - abort during RD_SAMPLE -> IDLE next edge, error=1, done=0.
- start pulsed while busy is ignored. WE_PULSE=3 -> each write strobe is low for exactly 3 cycles, with address/data stable one cycle before and after.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// Shared SAP RAM geometry and loader FSM encodings.
// Also imported by the RAM model so both sides agree on widths.
package mem_loader_pkg;

    localparam int SAP_ADDR_WIDTH = 4;
    localparam int SAP_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_SETUP     = 3'd2,
        ST_WRITE     = 3'd3,
        ST_HOLD      = 3'd4,
        ST_RD_ADDR   = 3'd5,
        ST_RD_SAMPLE = 3'd6,
        ST_CHECK     = 3'd7
    } state_t;

endpackage

// File: rtl/mem_loader_checksum.sv
// Mod-2^DATA_WIDTH running sum with synchronous clear and add.
// Latency: sum reflects an add on the next rising edge; clear wins over add.
// Backpressure: none, accepts an add every cycle.
module mem_loader_checksum
    import mem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = SAP_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  add_vld,
    input  logic [DATA_WIDTH-1:0] add_dat,
    output logic [DATA_WIDTH-1:0] sum
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (add_vld) begin
            sum <= sum + add_dat;
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Byte-stream programmer for the SAP RAM: writes every word in order, then reads back and compares sums.
// Latency: 3+WE_PULSE cycles per accepted byte, then 2*DEPTH+1 verify cycles before done.
// Backpressure: in_ready is high only while waiting for a byte; a stalled producer just parks the FSM.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = SAP_ADDR_WIDTH,
    parameter int DATA_WIDTH = SAP_DATA_WIDTH,
    parameter int WE_PULSE   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_write_enable,
    output logic                  mem_enable,
    input  logic [DATA_WIDTH-1:0] mem_bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int                 PULSE_W    = (WE_PULSE > 1) ? $clog2(WE_PULSE) : 1;
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(WE_PULSE - 1);

    state_t                state, state_nxt;
    logic [PULSE_W-1:0]    pulse_cnt, pulse_cnt_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic [DATA_WIDTH-1:0] wr_sum, rd_sum;
    logic                  we_n_nxt, oe_n_nxt, busy_nxt, done_nxt, error_nxt;
    logic                  kill, addr_last, load_go, wr_add, rd_add;

    assign kill      = abort && (state != ST_IDLE);
    assign addr_last = &mem_address;
    assign load_go   = (state == ST_IDLE) && start;
    assign in_ready  = (state == ST_WAIT_DATA);
    assign wr_add    = in_ready && in_valid && !kill;
    assign rd_add    = (state == ST_RD_SAMPLE) && !kill;

    mem_loader_checksum #(.DATA_WIDTH(DATA_WIDTH)) u_wr_sum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (load_go),
        .add_vld (wr_add),
        .add_dat (in_data),
        .sum     (wr_sum)
    );

    mem_loader_checksum #(.DATA_WIDTH(DATA_WIDTH)) u_rd_sum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (load_go),
        .add_vld (rd_add),
        .add_dat (mem_bus),
        .sum     (rd_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            pulse_cnt        <= '0;
            mem_address      <= '0;
            mem_data         <= '0;
            mem_write_enable <= 1'b1;
            mem_enable       <= 1'b1;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
        end else begin
            state            <= state_nxt;
            pulse_cnt        <= pulse_cnt_nxt;
            mem_address      <= addr_nxt;
            mem_data         <= data_nxt;
            mem_write_enable <= we_n_nxt;
            mem_enable       <= oe_n_nxt;
            busy             <= busy_nxt;
            done             <= done_nxt;
            error            <= error_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:      if (start) state_nxt = ST_WAIT_DATA;
                ST_WAIT_DATA: if (in_valid) state_nxt = ST_SETUP;
                ST_SETUP:     state_nxt = ST_WRITE;
                ST_WRITE:     if (pulse_cnt == PULSE_LAST) state_nxt = ST_HOLD;
                ST_HOLD:      state_nxt = addr_last ? ST_RD_ADDR : ST_WAIT_DATA;
                ST_RD_ADDR:   state_nxt = ST_RD_SAMPLE;
                ST_RD_SAMPLE: state_nxt = addr_last ? ST_CHECK : ST_RD_ADDR;
                ST_CHECK:     state_nxt = ST_IDLE;
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    // Strobes are decoded from the next state so they are registered yet aligned with it;
    // since WRITE and the read states are disjoint, the two strobes can never overlap.
    always_comb begin
        addr_nxt      = mem_address;
        data_nxt      = mem_data;
        busy_nxt      = busy;
        done_nxt      = done;
        error_nxt     = error;
        pulse_cnt_nxt = (state == ST_WRITE) ? pulse_cnt + 1'b1 : '0;
        we_n_nxt      = (state_nxt != ST_WRITE);
        oe_n_nxt      = !((state_nxt == ST_RD_ADDR) || (state_nxt == ST_RD_SAMPLE));
        if (kill) begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b0;
            error_nxt = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_nxt  = '0;
                        busy_nxt  = 1'b1;
                        done_nxt  = 1'b0;
                        error_nxt = 1'b0;
                    end
                end
                ST_WAIT_DATA: if (in_valid) data_nxt = in_data;
                ST_HOLD:      addr_nxt = addr_last ? '0 : mem_address + 1'b1;
                ST_RD_SAMPLE: if (!addr_last) addr_nxt = mem_address + 1'b1;
                ST_CHECK: begin
                    done_nxt = 1'b1;
                    busy_nxt = 1'b0;
                    // if/else rather than != so an unknown readback lands on the mismatch branch
                    if (wr_sum == rd_sum) error_nxt = 1'b0;
                    else                  error_nxt = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
